seg_roll_decoder: RTL

SEG_ROLL_DECODER -- requirements
Module: seg_roll_decoder

---
 rtl/seg_roll_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg_roll_decoder.sv
// Debounces a two-digit seven-segment die display and decodes stable patterns
// into a 1..20 roll, reporting each new stable pattern exactly once.
module seg_roll_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    output logic [4:0] value,
    output logic       valid,
    output logic       err,
    output logic       crit,
    output logic       fumble,
    output logic [7:0] roll_count
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] CNT_ARM = 4'(STABLE_CYCLES - 2);
    localparam logic [6:0] BLANK   = 7'h7F;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    state_t     state, state_next;
    logic [6:0] seg1_p0, seg2_p0;
    logic [3:0] cnt_p0;
    logic       match;
    logic       report;
    logic       blank;
    logic [4:0] tens_dec, ones_dec;
    logic       legal;
    logic [4:0] roll;

    // Returns {digit_ok, digit[3:0]} for an active-low segment code.
    function automatic logic [4:0] decode_digit(input logic [6:0] code);
        logic [4:0] res;
        case (code)
            7'h40:   res = {1'b1, 4'd0};
            7'h79:   res = {1'b1, 4'd1};
            7'h24:   res = {1'b1, 4'd2};
            7'h30:   res = {1'b1, 4'd3};
            7'h19:   res = {1'b1, 4'd4};
            7'h12:   res = {1'b1, 4'd5};
            7'h02:   res = {1'b1, 4'd6};
            7'h78:   res = {1'b1, 4'd7};
            7'h00:   res = {1'b1, 4'd8};
            7'h18:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Legality is judged on the digits themselves because 10*tens wraps at 5 bits.
    function automatic logic roll_legal(input logic [4:0] t, input logic [4:0] o);
        logic ok;
        ok = t[4] && o[4];
        case (t[3:0])
            4'd0:    ok = ok && (o[3:0] != 4'd0);
            4'd1:    ok = ok;
            4'd2:    ok = ok && (o[3:0] == 4'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign match    = (seg1 == seg1_p0) && (seg2 == seg2_p0);
    assign blank    = (seg1 == BLANK) && (seg2 == BLANK);
    assign tens_dec = decode_digit(seg1);
    assign ones_dec = decode_digit(seg2);
    assign legal    = roll_legal(tens_dec, ones_dec);
    assign roll     = 5'(tens_dec[3:0]) * 5'd10 + 5'(ones_dec[3:0]);

    always_comb begin
        state_next = state;
        report     = 1'b0;
        case (state)
            SETTLE: begin
                if (match && (cnt_p0 >= CNT_ARM)) begin
                    state_next = HOLD;
                    report     = 1'b1;
                end
            end
            HOLD: begin
                if (!match) begin
                    state_next = SETTLE;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    // Sample stage: register the input pair and track how long it has held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SETTLE;
            seg1_p0 <= BLANK;
            seg2_p0 <= BLANK;
            cnt_p0  <= 4'd0;
        end else begin
            state   <= state_next;
            seg1_p0 <= seg1;
            seg2_p0 <= seg2;
            if (!match) begin
                cnt_p0 <= 4'd0;
            end else if (cnt_p0 < CNT_MAX) begin
                cnt_p0 <= cnt_p0 + 4'd1;
            end
        end
    end

    // Report stage: pulses and the accepted roll.
    always_ff @(posedge clk) begin
        if (reset) begin
            value      <= 5'd1;
            valid      <= 1'b0;
            err        <= 1'b0;
            roll_count <= 8'd0;
        end else begin
            valid <= report && !blank && legal;
            err   <= report && !blank && !legal;
            if (report && !blank && legal) begin
                value      <= roll;
                roll_count <= roll_count + 8'd1;
            end
        end
    end

    assign crit   = (value == 5'd20);
    assign fumble = (value == 5'd1);

endmodule
